simon_core_arbiter: RTL

Shares one simon_rounds cipher core between two independent requesters, for example the SPI command front-end and a future on-chip stream engine.
- Each requester submits mode, block and key with a valid/ready handshake.
- The arbiter grants round-robin, latches operands, pulses the core start, waits for core completion, then returns the result on a per-requester response handshake.
- It also provides a timeout guard.

---
 rtl/simon_pkg.sv | 32 +++
 rtl/simon_core_arbiter_rr_arb2.sv | 40 ++++
 rtl/simon_core_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// +----------------------------------------------------------------------------+
// | simon_pkg : shared types and constants for the simon core arbiter slice   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package simon_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int BLOCK_W = 32;
  localparam int KEY_W   = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic               mode;
    logic [BLOCK_W-1:0] block;
    logic [KEY_W-1:0]   key;
  } core_op_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_core_arbiter_rr_arb2.sv
// +----------------------------------------------------------------------------+
// | rr_arb2  : combinational 2-way round-robin grant                           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (req_valid)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        // On a tie the requester not served last wins.
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end
      default: begin
        grant     = 2'b00;
        grant_idx = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/simon_core_arbiter.sv
// +----------------------------------------------------------------------------+
// | simon_core_arbiter : shares one simon_rounds core between two requesters   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module simon_core_arbiter
  import simon_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_mode,
  input  logic [2*BLOCK_W-1:0] req_block,
  input  logic [2*KEY_W-1:0]   req_key,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BLOCK_W-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 core_rst,
  output logic                 core_mode,
  output logic [BLOCK_W-1:0]   core_block,
  output logic [KEY_W-1:0]     core_key,
  input  logic [BLOCK_W-1:0]   core_ciphertext,
  input  logic                 core_done,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] GUARD_CNT    = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  core_op_t           op_q, op_d;
  logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         grant;
  logic               grant_idx;
  core_op_t           req_op;

  rr_arb2 u_rr_arb2 (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    req_op.mode  = req_mode[grant_idx];
    req_op.block = grant_idx ? req_block[2*BLOCK_W-1:BLOCK_W] : req_block[BLOCK_W-1:0];
    req_op.key   = grant_idx ? req_key[2*KEY_W-1:KEY_W]       : req_key[KEY_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        // grant is already qualified by req_valid, so a grant is a handshake.
        if (grant != 2'b00) begin
          op_d    = req_op;
          cur_d   = grant_idx;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The guard window masks a done level left over from the previous op.
        if ((cnt_q >= GUARD_CNT) && core_done) begin
          rsp_data_d = core_ciphertext;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[cur_q]) begin
          last_grant_d = cur_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      cnt_q        <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) ? grant : 2'b00;
    rsp_valid  = (state_q == ST_RESP) ? idx_to_onehot(cur_q) : 2'b00;
    core_rst   = (state_q == ST_START);
    busy       = (state_q != ST_IDLE);
    rsp_data   = rsp_data_q;
    rsp_err    = rsp_err_q;
    core_mode  = op_q.mode;
    core_block = op_q.block;
    core_key   = op_q.key;
  end

endmodule

`default_nettype wire
